// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide memory, MSB first, wrapping at DEPTH.
// Optional CHECKSUM_EN adds an XOR checksum of every byte written in the session.
module imem_loader #(
    parameter int DEPTH  = 65,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count
`ifdef CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [23:0]       word_reg;
    logic [1:0]        byte_idx_reg;
    logic              last_reg;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_A) ? '0 : p + 1'b1;
    endfunction

    // ptr_reg always holds the address of the next byte to be issued; the
    // byte currently on the memory port sits in mem_addr/mem_wdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            word_reg     <= '0;
            byte_idx_reg <= '0;
            last_reg     <= 1'b0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            word_count   <= '0;
`ifdef CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ptr_reg    <= base_addr % DEPTH_A;
                        word_count <= '0;
`ifdef CHECKSUM_EN
                        checksum   <= '0;
`endif
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        in_ready     <= 1'b0;
                        word_reg     <= in_data[23:0];
                        last_reg     <= in_last;
                        if (word_count != '1) begin
                            word_count <= word_count + 1'b1;
                        end
                        byte_idx_reg <= '0;
                        mem_we       <= 1'b1;
                        mem_addr     <= ptr_reg;
                        mem_wdata    <= in_data[31:24];
                        ptr_reg      <= next_ptr(ptr_reg);
`ifdef CHECKSUM_EN
                        checksum     <= checksum ^ in_data[31:24];
`endif
                        state_reg    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (byte_idx_reg == 2'd3) begin
                        mem_we <= 1'b0;
                        if (last_reg) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            in_ready  <= 1'b1;
                            state_reg <= ST_ACCEPT;
                        end
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                        mem_addr     <= ptr_reg;
                        mem_wdata    <= word_reg[23:16];
                        word_reg     <= {word_reg[15:0], 8'h00};
                        ptr_reg      <= next_ptr(ptr_reg);
`ifdef CHECKSUM_EN
                        checksum     <= checksum ^ word_reg[23:16];
`endif
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected byte writes and done
// pulses, a negedge monitor pops and compares them. Define CHECKSUM_EN to cover the checksum.
module tb_imem_loader;

    localparam int DEPTH  = 65;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  word_count;
`ifdef CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
`ifdef CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [15:0] wc;
        logic [7:0]  cks;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_ptr;
    int          m_wc;
    logic [7:0]  m_cks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every mem_we cycle and every done pulse must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        bit  ok;
        if (mem_we === 1'b1) begin
            compared++;
            if (wr_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: cyc=%0d addr=%0d data=%02h, none required",
                         cyc, mem_addr, mem_wdata);
            end else begin
                e = wr_q.pop_front();
                if (cyc != e.cyc || mem_addr !== e.addr || mem_wdata !== e.data) begin
                    mismatched++;
                    $display("FAIL write: got cyc=%0d addr=%0d data=%02h, required cyc=%0d addr=%0d data=%02h",
                             cyc, mem_addr, mem_wdata, e.cyc, e.addr, e.data);
                end else begin
                    $display("ok   write: cyc=%0d addr=%0d data=%02h", cyc, mem_addr, mem_wdata);
                end
            end
        end
        if (done === 1'b1) begin
            compared++;
            if (dn_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: cyc=%0d word_count=%0d, none required", cyc, word_count);
            end else begin
                d  = dn_q.pop_front();
                ok = (cyc == d.cyc) && (word_count === d.wc);
`ifdef CHECKSUM_EN
                ok = ok && (checksum === d.cks);
                $display("%s done: got cyc=%0d wc=%0d cks=%02h, required cyc=%0d wc=%0d cks=%02h",
                         ok ? "ok  " : "FAIL", cyc, word_count, checksum, d.cyc, d.wc, d.cks);
`else
                $display("%s done: got cyc=%0d wc=%0d, required cyc=%0d wc=%0d",
                         ok ? "ok  " : "FAIL", cyc, word_count, d.cyc, d.wc);
`endif
                if (!ok) mismatched++;
            end
        end
    end

    task automatic do_start(input logic [31:0] b);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = '0;
        m_ptr     = 32'(b % DEPTH);
        m_wc      = 0;
        m_cks     = 8'h00;
    endtask

    // Queue only the first nbytes writes; a done pulse is expected only for a full last word.
    task automatic send(input logic [31:0] w, input logic last, input int nbytes);
        int   t;
        int   c;
        wr_t  e;
        dn_t  d;
        logic [7:0] b;
        in_data  = w;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready=%b after 50 cycles, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        c = cyc;
        m_wc++;
        for (int k = 0; k < 4; k++) begin
            b = w[31-8*k -: 8];
            if (k < nbytes) begin
                e.cyc  = c + 1 + k;
                e.addr = m_ptr;
                e.data = b;
                wr_q.push_back(e);
            end
            m_cks = m_cks ^ b;
            m_ptr = (m_ptr == 32'(DEPTH - 1)) ? 32'd0 : m_ptr + 32'd1;
        end
        if (last && nbytes == 4) begin
            d.cyc = c + 5;
            d.wc  = 16'(m_wc);
            d.cks = m_cks;
            dn_q.push_back(d);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((wr_q.size() != 0 || dn_q.size() != 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (wr_q.size() != 0 || dn_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d writes and %0d done pulses outstanding, required 0",
                     wr_q.size(), dn_q.size());
            wr_q.delete();
            dn_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        base_addr = 32'd5;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset_word_count", 32'(word_count), 32'd0);
`ifdef CHECKSUM_EN
        check("reset_checksum", 32'(checksum), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_reset_ignored_busy", 32'(busy), 32'd0);
        check("start_in_reset_ignored_ready", 32'(in_ready), 32'd0);

        // Single word at address 0.
        do_start(32'd0);
        send(32'h2008_0005, 1'b1, 4);
        drain();
        check("single_word_count", 32'(word_count), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);

        // Wrap from 63 through 64 back to 0.
        do_start(32'd63);
        send(32'hAABB_CCDD, 1'b1, 4);
        drain();

        // Three words with idle gaps in ACCEPT.
        do_start(32'd0);
        send(32'h0102_0304, 1'b0, 4);
        repeat (6) @(negedge clk);
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_in_ready", 32'(in_ready), 32'd1);
        send(32'h5566_7788, 1'b0, 4);
        repeat (6) @(negedge clk);
        send(32'h99AA_BBCC, 1'b1, 4);
        drain();
        check("three_word_count", 32'(word_count), 32'd3);

        // Reset after the second byte of a word, then restart elsewhere.
        do_start(32'd20);
        send(32'h1122_3344, 1'b1, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_mem_we", 32'(mem_we), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_word_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_start(32'd40);
        send(32'hCAFE_F00D, 1'b1, 4);
        drain();
        check("restart_word_count", 32'(word_count), 32'd1);

        // Two words whose bytes XOR to 0x44.
        do_start(32'd130);
        send(32'h0102_0304, 1'b0, 4);
        send(32'h1020_3040, 1'b1, 4);
        drain();
        check("two_word_count", 32'(word_count), 32'd2);
`ifdef CHECKSUM_EN
        check("checksum_hold", 32'(checksum), 32'h44);
`endif

        repeat (4) @(negedge clk);
        check("write_queue_empty", 32'(wr_q.size()), 32'd0);
        check("done_queue_empty", 32'(dn_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
